// File: rtl/gray_step_tracker_pkg.sv
// Shared types and default sizing for the Gray step tracker and its helpers.
package gray_step_tracker_pkg;

  localparam int unsigned W_DEF  = 3;
  localparam int unsigned CW_DEF = 8;
  localparam int unsigned EW_DEF = 4;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } trk_state_e;

endpackage

// File: rtl/gray_step_tracker_gray2bin.sv
// Pure combinational Gray-to-binary decode, reusable by any Gray consumer.
module gray2bin #(
  parameter int unsigned W = 3
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin_c
);

  logic [W-1:0] acc;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    acc = gray;
    for (int i = int'(W) - 2; i >= 0; i--) begin
      acc[i] = acc[i+1] ^ gray[i];
    end
    bin_c = acc;
  end

endmodule

// File: rtl/gray_step_tracker.sv
// Tracks a Gray-coded position bus: classifies hold / up / down / illegal jump.
// Define GRAY_STEP_TRACKER_SYNC_EN to put a 2-flop synchronizer on gray_in.
module gray_step_tracker
  import gray_step_tracker_pkg::*;
#(
  parameter int unsigned W  = W_DEF,
  parameter int unsigned CW = CW_DEF,
  parameter int unsigned EW = EW_DEF
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [W-1:0]  gray_in,
  input  logic          sample_en,
  input  logic          clear,
  output logic [W-1:0]  bin_out,
  output logic          dir,
  output logic          step,
  output logic          wrap,
  output logic          err,
  output logic          err_sticky,
  output logic [EW-1:0] err_count,
  output logic [CW-1:0] pos
);

  logic [W-1:0] gray_use;
  logic [W-1:0] bin_new;
  logic [W-1:0] ref_q;
  logic [W-1:0] diff;
  logic         is_hold;
  logic         is_up;
  logic         is_dn;
  trk_state_e   state;

`ifdef GRAY_STEP_TRACKER_SYNC_EN
  logic [W-1:0] sync_q1;
  logic [W-1:0] sync_q2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= gray_in;
      sync_q2 <= sync_q1;
    end
  end

  assign gray_use = sync_q2;
`else
  assign gray_use = gray_in;
`endif

  gray2bin #(.W(W)) u_gray2bin (
    .gray  (gray_use),
    .bin_c (bin_new)
  );

  // Modular distance from the reference picks the step class.
  always_comb begin
    diff    = bin_new - ref_q;
    is_hold = (diff == '0);
    is_up   = (diff == W'(1));
    is_dn   = (diff == '1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_INIT;
      ref_q      <= '0;
      bin_out    <= '0;
      dir        <= 1'b0;
      step       <= 1'b0;
      wrap       <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
      pos        <= '0;
    end else begin
      step <= 1'b0;
      wrap <= 1'b0;
      err  <= 1'b0;
      if (clear) begin
        // Clear wins over a coincident sample; bin_out and dir are kept.
        state      <= ST_INIT;
        pos        <= '0;
        err_sticky <= 1'b0;
        err_count  <= '0;
      end else if (sample_en) begin
        ref_q   <= bin_new;
        bin_out <= bin_new;
        case (state)
          ST_INIT, ST_FAULT: state <= ST_TRACK;
          ST_TRACK: begin
            if (is_up) begin
              step <= 1'b1;
              dir  <= 1'b1;
              wrap <= (ref_q == '1);
              pos  <= pos + CW'(1);
            end else if (is_dn) begin
              step <= 1'b1;
              dir  <= 1'b0;
              wrap <= (ref_q == '0);
              pos  <= pos - CW'(1);
            end else if (!is_hold) begin
              err        <= 1'b1;
              err_sticky <= 1'b1;
              if (err_count != '1) err_count <= err_count + EW'(1);
              state      <= ST_FAULT;
            end
          end
          default: state <= ST_INIT;
        endcase
      end
    end
  end

endmodule
